mux_nt1_reg: RTL and testbench

MUX_NT1_REG -- requirements
Module: mux_nt1_reg

---
 rtl/mux_nt1_reg.sv | 115 +++++++++++
 tb/tb_mux_nt1_reg.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_nt1_reg.sv
// Registered N:1 multiplexer with a valid/ready handshake on each side.
// Channels are picked by direct select (mode=0) or round-robin (mode=1).
module mux_nt1_reg #(
    parameter int WIDTH = 64,
    parameter int N     = 2,
    parameter int SW    = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic [SW-1:0]      sel,
    input  logic [N*WIDTH-1:0] i_data,
    input  logic [N-1:0]       i_valid,
    output logic [N-1:0]       i_ready,
    output logic [WIDTH-1:0]   o,
    output logic               o_valid,
    input  logic               o_ready,
    output logic [SW-1:0]      o_src,
    output logic               err
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic [SW-1:0]    r_src;
    logic [SW-1:0]    r_rrPtr;
    logic             r_err;

    logic             w_loadOk;
    logic             w_selBad;
    logic             w_grantHit;
    logic [SW-1:0]    w_grantIdx;
    logic [N-1:0]     w_grantOneHot;
    logic             w_xferIn;
    logic [SW-1:0]    w_nextPtr;
    logic [WIDTH-1:0] w_grantData;

    assign w_loadOk = !r_valid || o_ready;
    assign w_selBad = ({1'b0, sel} >= (SW+1)'(N));

    // Round-robin search starts at r_rrPtr and wraps past N-1 back to 0.
    always_comb begin : grantLogic
        int            cand;
        logic [SW-1:0] candIdx;
        cand       = 0;
        candIdx    = '0;
        w_grantHit = 1'b0;
        w_grantIdx = '0;
        if (!mode) begin
            if (!w_selBad && i_valid[sel]) begin
                w_grantHit = 1'b1;
                w_grantIdx = sel;
            end
        end else begin
            for (int j = 0; j < N; j++) begin
                cand = int'(r_rrPtr) + j;
                if (cand >= N) begin
                    cand = cand - N;
                end
                candIdx = SW'(cand);
                if (!w_grantHit && i_valid[candIdx]) begin
                    w_grantHit = 1'b1;
                    w_grantIdx = candIdx;
                end
            end
        end
    end

    always_comb begin
        w_grantOneHot = '0;
        w_grantData   = '0;
        if (w_grantHit) begin
            w_grantOneHot[w_grantIdx] = 1'b1;
        end
        for (int j = 0; j < N; j++) begin
            if (w_grantIdx == SW'(j)) begin
                w_grantData = i_data[j*WIDTH +: WIDTH];
            end
        end
    end

    // No channel may be accepted while reset is held, even before the first edge.
    assign i_ready   = (rst && w_loadOk && w_grantHit) ? w_grantOneHot : '0;
    assign w_xferIn  = |i_ready;
    assign w_nextPtr = (int'(w_grantIdx) == N - 1) ? '0 : w_grantIdx + SW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_src   <= '0;
            r_rrPtr <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_xferIn) begin
                r_data  <= w_grantData;
                r_src   <= w_grantIdx;
                r_valid <= 1'b1;
                if (mode) begin
                    r_rrPtr <= w_nextPtr;
                end
            end else if (r_valid && o_ready) begin
                r_valid <= 1'b0;
            end
            if (!mode && w_selBad && (|i_valid)) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o       = r_data;
    assign o_valid = r_valid;
    assign o_src   = r_src;
    assign err     = r_err;

endmodule

// File: tb/tb_mux_nt1_reg.sv
// Bench for mux_nt1_reg with N=3: directed scenarios plus random traffic,
// all checked against a behavioural model of the select/arbitration rules.
module tb_mux_nt1_reg;

    localparam int WIDTH = 64;
    localparam int N     = 3;
    localparam int SW    = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               mode = 1'b0;
    logic [SW-1:0]      sel = '0;
    logic [N*WIDTH-1:0] iData = '0;
    logic [N-1:0]       iValid = '0;
    logic [N-1:0]       iReady;
    logic [WIDTH-1:0]   o;
    logic               oValid;
    logic               oReady = 1'b0;
    logic [SW-1:0]      oSrc;
    logic               err;

    int checks = 0;
    int errors = 0;
    bit compareEn = 1'b0;

    logic [WIDTH-1:0] mOut   = '0;
    logic             mValid = 1'b0;
    int               mSrc   = 0;
    int               mPtr   = 0;
    logic             mErr   = 1'b0;

    mux_nt1_reg #(.WIDTH(WIDTH), .N(N), .SW(SW)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .i_data(iData), .i_valid(iValid), .i_ready(iReady),
        .o(o), .o_valid(oValid), .o_ready(oReady), .o_src(oSrc), .err(err)
    );

    initial forever #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic m, input logic [SW-1:0] s, input logic [N-1:0] v,
                                 input logic [N*WIDTH-1:0] d, input logic r);
        mode   = m;
        sel    = s;
        iValid = v;
        iData  = d;
        oReady = r;
    endtask

    function automatic logic [N*WIDTH-1:0] pack3(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                 input logic [WIDTH-1:0] c);
        return {c, b, a};
    endfunction

    // Which channel the rules say wins this cycle; -1 means nobody.
    function automatic int modelGrant(input logic m, input logic [SW-1:0] s, input logic [N-1:0] v, input int ptr);
        if (!m) begin
            if (int'(s) < N) begin
                if (v[s]) return int'(s);
            end
            return -1;
        end
        for (int j = 0; j < N; j++) begin
            int k = (ptr + j) % N;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mOut = '0; mValid = 1'b0; mSrc = 0; mPtr = 0; mErr = 1'b0;
        end else begin
            int g;
            g = modelGrant(mode, sel, iValid, mPtr);
            if ((!mValid || oReady) && g >= 0) begin
                mOut   = iData[g*WIDTH +: WIDTH];
                mSrc   = g;
                mValid = 1'b1;
                if (mode) mPtr = (g + 1) % N;
            end else if (mValid && oReady) begin
                mValid = 1'b0;
            end
            if (!mode && int'(sel) >= N && iValid != '0) mErr = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (compareEn) begin
            int g;
            logic [N-1:0] expReady;
            g = modelGrant(mode, sel, iValid, mPtr);
            expReady = '0;
            if (rst && (!mValid || oReady) && g >= 0) expReady[g] = 1'b1;
            checkOutput("cmp_i_ready", WIDTH'(iReady), WIDTH'(expReady));
            checkOutput("cmp_o", o, mOut);
            checkOutput("cmp_o_valid", WIDTH'(oValid), WIDTH'(mValid));
            checkOutput("cmp_o_src", WIDTH'(oSrc), WIDTH'(mSrc));
            checkOutput("cmp_err", WIDTH'(err), WIDTH'(mErr));
        end
    end

    task automatic randomCycles(input int count);
        for (int i = 0; i < count; i++) begin
            @(posedge clk); #1;
            applyStimulus(1'($urandom_range(0, 1)), SW'($urandom_range(0, 3)), N'($urandom_range(0, 7)),
                          pack3({$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}),
                          ($urandom_range(0, 3) != 0));
        end
    endtask

    initial begin
        int rrSeq[6];
        int oddSeq[3];
        rrSeq  = '{0, 1, 2, 0, 1, 2};
        oddSeq = '{2, 0, 2};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_o", o, 64'h0);
        checkOutput("rst_o_valid", WIDTH'(oValid), 64'h0);
        checkOutput("rst_o_src", WIDTH'(oSrc), 64'h0);
        checkOutput("rst_err", WIDTH'(err), 64'h0);
        checkOutput("rst_i_ready", WIDTH'(iReady), 64'h0);
        rst = 1'b1;
        compareEn = 1'b1;

        // Direct select of channel 1.
        applyStimulus(1'b0, 2'd1, 3'b011, pack3(64'hA, 64'hB, 64'hC), 1'b1);
        #1 checkOutput("sel1_i_ready", WIDTH'(iReady), 64'h2);
        @(posedge clk); #1;
        checkOutput("sel1_o", o, 64'hB);
        checkOutput("sel1_o_src", WIDTH'(oSrc), 64'h1);
        checkOutput("sel1_o_valid", WIDTH'(oValid), 64'h1);

        // Round-robin with all channels requesting.
        applyStimulus(1'b1, 2'd0, 3'b111, pack3(64'hA, 64'hB, 64'hC), 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checkOutput("rr_all_o_src", WIDTH'(oSrc), WIDTH'(rrSeq[i]));
        end

        // Move pointer to 1, then channel 1 idle: grants 2,0,2.
        applyStimulus(1'b1, 2'd0, 3'b001, pack3(64'hA, 64'hB, 64'hC), 1'b1);
        @(posedge clk); #1;
        checkOutput("rr_ptr1_o_src", WIDTH'(oSrc), 64'h0);
        applyStimulus(1'b1, 2'd0, 3'b101, pack3(64'hA, 64'hB, 64'hC), 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkOutput("rr_skip_o_src", WIDTH'(oSrc), WIDTH'(oddSeq[i]));
        end

        // Backpressure: held word stays put while inputs churn.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 2'd0, 3'b001, pack3(64'h100 + 64'(i), 64'hB, 64'hC), 1'b0);
            #1 checkOutput("stall_i_ready", WIDTH'(iReady), 64'h0);
            @(posedge clk); #1;
            checkOutput("stall_o", o, 64'hC);
        end
        applyStimulus(1'b0, 2'd0, 3'b001, pack3(64'h1234, 64'hB, 64'hC), 1'b1);
        #1 checkOutput("unstall_i_ready", WIDTH'(iReady), 64'h1);
        @(posedge clk); #1;
        checkOutput("unstall_o", o, 64'h1234);
        checkOutput("unstall_o_src", WIDTH'(oSrc), 64'h0);

        // Out-of-range select raises sticky err and grants nothing.
        applyStimulus(1'b0, 2'd3, 3'b001, pack3(64'hA, 64'hB, 64'hC), 1'b1);
        #1 checkOutput("badsel_i_ready", WIDTH'(iReady), 64'h0);
        @(posedge clk); #1;
        checkOutput("badsel_err", WIDTH'(err), 64'h1);
        checkOutput("badsel_o_valid", WIDTH'(oValid), 64'h0);
        applyStimulus(1'b0, 2'd0, 3'b000, pack3(64'hA, 64'hB, 64'hC), 1'b1);
        @(posedge clk); #1;
        checkOutput("sticky_err", WIDTH'(err), 64'h1);

        randomCycles(600);

        // Load a word, hold it, then reset between edges.
        applyStimulus(1'b0, 2'd1, 3'b010, pack3(64'hA, 64'hB, 64'hC), 1'b1);
        @(posedge clk); #1;
        applyStimulus(1'b0, 2'd1, 3'b010, pack3(64'hA, 64'hB, 64'hC), 1'b0);
        #2 rst = 1'b0;
        #1;
        checkOutput("midrst_o_valid", WIDTH'(oValid), 64'h0);
        checkOutput("midrst_o", o, 64'h0);
        checkOutput("midrst_o_src", WIDTH'(oSrc), 64'h0);
        checkOutput("midrst_err", WIDTH'(err), 64'h0);
        checkOutput("midrst_i_ready", WIDTH'(iReady), 64'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        applyStimulus(1'b1, 2'd0, 3'b111, pack3(64'hA, 64'hB, 64'hC), 1'b1);
        @(posedge clk); #1;
        checkOutput("postrst_o_src", WIDTH'(oSrc), 64'h0);
        checkOutput("postrst_o_valid", WIDTH'(oValid), 64'h1);

        randomCycles(600);

        @(posedge clk); #1;
        compareEn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
